mem_dump_engine: RTL

- Hardware successor to the simulation memory-dump hook; synthesizable, sits beside mips_cpu and the data memory BRAM.
- Watches the CPU register-file write port and streams trace records (pc, waddr, wdata).
- On a halt condition (a store of HALT_DATA to HALT_ADDR), or on a software trigger, stalls the CPU, then reads out the whole memory through a BRAM read port.
- Emits the memory as packed multi-word lines on a valid/ready stream.

---
 rtl/mem_dump_pkg.sv | 34 +++
 rtl/mem_dump_fifo.sv | 48 ++++
 rtl/mem_dump_engine.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mem_dump_pkg.sv
// +------------------------------------------------------------------+
// | mem_dump_pkg: shared types and helpers for the memory dump engine |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
`default_nettype none

package mem_dump_pkg;

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_DRAIN = 3'd1,
    ST_READ  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_EMIT  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic OUT_KIND_TRACE = 1'b0;
  localparam logic OUT_KIND_DUMP  = 1'b1;

  localparam int TRACE_WORD_W = 32;

  // Leading three lanes of a trace record: pc, zero-extended waddr, wdata.
  function automatic logic [3*TRACE_WORD_W-1:0] pack_trace(
    input logic [TRACE_WORD_W-1:0] pc,
    input logic [4:0]              waddr,
    input logic [TRACE_WORD_W-1:0] wdata
  );
    return {pc, {(TRACE_WORD_W-5){1'b0}}, waddr, wdata};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_dump_fifo.sv
// +------------------------------------------------------------------+
// | mem_dump_fifo: synchronous FIFO with full/empty flags             |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
`default_nettype none

module mem_dump_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wptr;
  logic [PW:0]      rptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)  wptr <= wptr + 1'b1;
      if (pop  && !empty) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[PW-1:0]] <= wdata;
  end

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign rdata = mem[rptr[PW-1:0]];

endmodule

`default_nettype wire

// File: rtl/mem_dump_engine.sv
// +------------------------------------------------------------------+
// | mem_dump_engine: register-write trace plus halt-triggered memdump |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
`default_nettype none

module mem_dump_engine
  import mem_dump_pkg::*;
#(
  parameter int               DATA_W         = 32,
  parameter int               MEM_DEPTH      = 4096,
  parameter int               WORDS_PER_LINE = 4,
  parameter logic [DATA_W-1:0] HALT_ADDR     = 32'd12,
  parameter logic [DATA_W-1:0] HALT_DATA     = 32'd0,
  parameter int               RD_LATENCY     = 1,
  parameter int               TRACE_EN       = 1,
  parameter int               TRACE_DEPTH    = 8
) (
  input  logic                               mips_cpu_clk,
  input  logic                               mips_cpu_reset_n,
  input  logic                               mon_mem_write,
  input  logic [DATA_W-1:0]                  mon_addr,
  input  logic [DATA_W-1:0]                  mon_wdata,
  input  logic                               mon_rf_wen,
  input  logic [4:0]                         mon_rf_waddr,
  input  logic [DATA_W-1:0]                  mon_rf_wdata,
  input  logic [DATA_W-1:0]                  mon_pc,
  input  logic                               sw_trigger,
  output logic                               cpu_halt_req,
  output logic                               mem_rd_en,
  output logic [$clog2(MEM_DEPTH)-1:0]       mem_rd_addr,
  input  logic [DATA_W-1:0]                  mem_rd_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [WORDS_PER_LINE*DATA_W-1:0]   out_data,
  output logic                               out_kind,
  output logic                               out_last,
  output logic                               busy,
  output logic                               done,
  output logic                               trace_ovf
);

  localparam int AW     = $clog2(MEM_DEPTH);
  localparam int LW     = $clog2(WORDS_PER_LINE);
  localparam int LINE_W = WORDS_PER_LINE * DATA_W;
  localparam int FW     = DATA_W - 2;
  localparam logic [AW:0]   WC_END    = (AW+1)'(MEM_DEPTH);
  localparam logic [LW-1:0] LANE_LAST = LW'(WORDS_PER_LINE - 1);
  localparam logic [1:0]    LAT_LAST  = 2'(RD_LATENCY - 1);

  state_t              state;
  state_t              state_nx;
  logic [AW:0]         wc;
  logic [1:0]          lat_cnt;
  logic [DATA_W-1:0]   line_q [WORDS_PER_LINE];
  logic [LINE_W-1:0]   line_flat;
  logic                armed;
  logic                fwd_valid;
  logic [FW-1:0]       fwd_idx;
  logic [DATA_W-1:0]   fwd_data;
  logic                store_hit;
  logic                trig;
  logic                push_req;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [LINE_W-1:0]   fifo_head;
  logic [LINE_W-1:0]   rec;
  logic [3*DATA_W-1:0] rec_head;
  logic [LW-1:0]       lane;
  logic                lat_done;
  logic                fwd_hit;

  assign store_hit = mon_mem_write && (mon_addr == HALT_ADDR) && (mon_wdata == HALT_DATA);
  assign trig      = armed && (store_hit || sw_trigger);
  assign push_req  = (TRACE_EN != 0) && (state == ST_RUN) && mon_rf_wen && (mon_rf_waddr != 5'd0);
  assign lane      = wc[LW-1:0];
  assign lat_done  = (lat_cnt == LAT_LAST);
  // A store trigger has not reached the BRAM yet, so its data is substituted.
  assign fwd_hit   = fwd_valid && (FW'(wc) == fwd_idx);

  if (DATA_W == TRACE_WORD_W) begin : g_rec_pkg
    assign rec_head = pack_trace(mon_pc, mon_rf_waddr, mon_rf_wdata);
  end else begin : g_rec_gen
    assign rec_head = {mon_pc, {(DATA_W-5){1'b0}}, mon_rf_waddr, mon_rf_wdata};
  end
  assign rec = {rec_head, {(LINE_W-3*DATA_W){1'b0}}};

  for (genvar i = 0; i < WORDS_PER_LINE; i++) begin : g_pack
    assign line_flat[(WORDS_PER_LINE-1-i)*DATA_W +: DATA_W] = line_q[i];
  end

  mem_dump_fifo #(
    .WIDTH (LINE_W),
    .DEPTH (TRACE_DEPTH)
  ) u_fifo (
    .clk   (mips_cpu_clk),
    .rst_n (mips_cpu_reset_n),
    .push  (push_req),
    .pop   (fifo_pop),
    .wdata (rec),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge mips_cpu_clk or negedge mips_cpu_reset_n) begin
    if (!mips_cpu_reset_n) state <= ST_RUN;
    else                   state <= state_nx;
  end

  always_ff @(posedge mips_cpu_clk or negedge mips_cpu_reset_n) begin
    if (!mips_cpu_reset_n) begin
      armed        <= 1'b1;
      cpu_halt_req <= 1'b0;
      fwd_valid    <= 1'b0;
      fwd_idx      <= '0;
      fwd_data     <= '0;
      trace_ovf    <= 1'b0;
      wc           <= '0;
      lat_cnt      <= '0;
      for (int i = 0; i < WORDS_PER_LINE; i++) line_q[i] <= '0;
    end else begin
      if (trig) begin
        armed        <= 1'b0;
        cpu_halt_req <= 1'b1;
        fwd_valid    <= store_hit;
        fwd_idx      <= mon_addr[DATA_W-1:2];
        fwd_data     <= mon_wdata;
      end
      if (push_req && fifo_full) trace_ovf <= 1'b1;
      if (state == ST_DRAIN) wc <= '0;
      if (state == ST_READ)  lat_cnt <= '0;
      if (state == ST_WAIT) begin
        if (lat_done) begin
          line_q[lane] <= fwd_hit ? fwd_data : mem_rd_data;
          wc           <= wc + 1'b1;
        end else begin
          lat_cnt <= lat_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nx  = state;
    mem_rd_en = 1'b0;
    out_valid = 1'b0;
    out_kind  = OUT_KIND_TRACE;
    out_last  = 1'b0;
    out_data  = '0;
    fifo_pop  = 1'b0;
    if (!fifo_empty) begin
      out_valid = 1'b1;
      out_data  = fifo_head;
      fifo_pop  = out_ready;
    end
    unique case (state)
      ST_RUN:   if (trig) state_nx = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_nx = ST_READ;
      ST_READ: begin
        mem_rd_en = 1'b1;
        state_nx  = ST_WAIT;
      end
      ST_WAIT:  if (lat_done) state_nx = (lane == LANE_LAST) ? ST_EMIT : ST_READ;
      ST_EMIT: begin
        out_valid = 1'b1;
        out_kind  = OUT_KIND_DUMP;
        out_last  = (wc == WC_END);
        out_data  = line_flat;
        fifo_pop  = 1'b0;
        if (out_ready) state_nx = (wc == WC_END) ? ST_DONE : ST_READ;
      end
      ST_DONE:  state_nx = ST_DONE;
      default:  state_nx = ST_RUN;
    endcase
  end

  assign mem_rd_addr = wc[AW-1:0];
  assign busy        = (state == ST_DRAIN) || (state == ST_READ) ||
                       (state == ST_WAIT)  || (state == ST_EMIT);
  assign done        = (state == ST_DONE);

endmodule

`default_nettype wire
